cmd_frame_exec: RTL and testbench

Parametrised command-frame executor for the badge UART path. It takes complete fixed-length frames from the UART receive FIFO and checks the framing (opcode byte must equal end-marker byte). It can optionally XOR-decrypt an inner command, executes register write/read on an internal bank of 8-bit control registers (LED/PWM/status), and returns a status frame over a valid/ready handshake to the UART transmit side.

---
 rtl/cmd_frame_exec.sv | 176 +++++++++++++++++
 tb/tb_cmd_frame_exec.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_exec.sv
// Command-frame executor: checks the frame marker, optionally XOR-decrypts, runs W/R on a register bank.
// Define CMD_FRAME_EXEC_XOR_EN to build the DECRYPT state and the "X" opcode.
module cmd_frame_exec #(
    parameter int                           FRAME_BYTES = 18,
    parameter int                           NUM_REGS    = 8,
    parameter logic [8*(FRAME_BYTES-2)-1:0] XOR_KEY     = "1234567890123456"
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     frame_valid,
    input  logic [8*FRAME_BYTES-1:0] frame_in,
    output logic                     frame_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [8*FRAME_BYTES-1:0] resp_data,
    output logic [8*NUM_REGS-1:0]    reg_out,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam int FW = 8*FRAME_BYTES;
    localparam int PW = 8*(FRAME_BYTES-2);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DECRYPT, S_EXEC, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [7:0]      op_q, op_d, idx_q, idx_d, val_q, val_d, status_q, status_d;
    logic [FW-1:0]   resp_q, resp_d;
    logic            resp_valid_q, resp_valid_d;
    logic [7:0]      err_q, err_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic            wr_en;
    logic [7:0]      rd_val;
    logic            ovr, rsp_err;
    logic [8:0]      err_sum;

`ifdef CMD_FRAME_EXEC_XOR_EN
    logic [PW-1:0] dec_w;
    assign dec_w = frame_q[FW-9:8] ^ XOR_KEY;
`else
    logic unused_payload;
    assign unused_payload = ^frame_q[FW-9:24];
`endif

    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == 8'(i)) rd_val = regs_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        op_d         = op_q;
        idx_d        = idx_q;
        val_d        = val_q;
        status_d     = status_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        wr_en        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    frame_d = frame_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                op_d  = frame_q[7:0];
                idx_d = frame_q[15:8];
                val_d = frame_q[23:16];
                if (frame_q[7:0] != frame_q[FW-1 -: 8]) begin
                    status_d = "F";
                    state_d  = S_RESP;
                end
`ifdef CMD_FRAME_EXEC_XOR_EN
                else if (frame_q[7:0] == "X") begin
                    state_d = S_DECRYPT;
                end
`endif
                else begin
                    state_d = S_EXEC;
                end
            end
`ifdef CMD_FRAME_EXEC_XOR_EN
            S_DECRYPT: begin
                op_d  = dec_w[7:0];
                idx_d = dec_w[15:8];
                val_d = dec_w[23:16];
                if (dec_w[7:0] != dec_w[PW-1 -: 8]) begin
                    status_d = "F";
                    state_d  = S_RESP;
                end else begin
                    state_d = S_EXEC;
                end
            end
`endif
            S_EXEC: begin
                // a decrypted "X" lands here too and is rejected as unknown
                if (op_q != "W" && op_q != "R") status_d = "I";
                else if ({1'b0, idx_q} >= 9'(NUM_REGS)) status_d = "A";
                else status_d = "K";
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d  = 1'b1;
                    resp_d        = '0;
                    resp_d[7:0]   = status_q;
                    if (status_q != "F") resp_d[15:8] = idx_q;
                    if (status_q == "K") resp_d[23:16] = (op_q == "W") ? val_q : rd_val;
                    wr_en = (status_q == "K") && (op_q == "W");
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // overrun and error responses may land in the same cycle; both count
    always_comb begin
        ovr     = frame_valid && (state_q != S_IDLE);
        rsp_err = (state_q == S_RESP) && !resp_valid_q && (status_q != "K");
        err_sum = {1'b0, err_q} + {8'd0, ovr} + {8'd0, rsp_err};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            op_q         <= '0;
            idx_q        <= '0;
            val_q        <= '0;
            status_q     <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            status_q     <= status_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'hFF;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && idx_q == 8'(i)) regs_q[i] <= val_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[8*g +: 8] = regs_q[g];
    end

    assign frame_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_cmd_frame_exec.sv
// Self-checking bench for cmd_frame_exec: scoreboard queue of expected responses, one task per scenario.
// Follows CMD_FRAME_EXEC_XOR_EN the same way the design does.
module tb_cmd_frame_exec;

    localparam int FB = 18;
    localparam int NR = 8;
    localparam int FW = 8*FB;
    localparam int PW = 8*(FB-2);
    localparam logic [PW-1:0] KEY = "1234567890123456";

    logic          clk;
    logic          nreset;
    logic          frame_valid;
    logic [FW-1:0] frame_in;
    logic          frame_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic [FW-1:0] resp_data;
    logic [8*NR-1:0] reg_out;
    logic [7:0]    err_count;
    logic          busy;

    typedef struct {
        logic [7:0] st;
        logic [7:0] idx;
        logic [7:0] val;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_regs [NR];
    int         exp_err;
    int         n_checks;
    int         n_pass;

    cmd_frame_exec #(.FRAME_BYTES(FB), .NUM_REGS(NR), .XOR_KEY(KEY)) dut (
        .clk(clk), .nreset(nreset), .frame_valid(frame_valid), .frame_in(frame_in),
        .frame_ready(frame_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .reg_out(reg_out), .err_count(err_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [FW-1:0] mk(input logic [7:0] op, input logic [7:0] idx,
                                         input logic [7:0] val, input logic [7:0] mark);
        logic [FW-1:0] f;
        f = '0;
        f[7:0]     = op;
        f[15:8]    = idx;
        f[23:16]   = val;
        f[FW-1 -: 8] = mark;
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_resp(input exp_t e);
        logic [FW-1:0] f;
        f = '0;
        f[7:0]   = e.st;
        f[15:8]  = e.idx;
        f[23:16] = e.val;
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_enc(input logic [7:0] op, input logic [7:0] idx,
                                             input logic [7:0] val);
        logic [PW-1:0] d;
        d = '0;
        d[7:0]       = op;
        d[15:8]      = idx;
        d[23:16]     = val;
        d[PW-1 -: 8] = op;
        return {8'h58, d ^ KEY, 8'h58};
    endfunction

    function automatic logic [8*NR-1:0] bank();
        logic [8*NR-1:0] b;
        for (int i = 0; i < NR; i++) b[8*i +: 8] = exp_regs[i];
        return b;
    endfunction

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    // drives one frame, then waits (bounded) for resp_valid; lat = -1 on timeout
    task automatic send(input logic [FW-1:0] f, output int lat, output logic [FW-1:0] data);
        @(negedge clk);
        frame_in    = f;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        data = resp_data;
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (frame_ready !== 1'b1) $display("FAIL reset_frame_ready: got %b exp 1", frame_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (err_count !== 8'h00) $display("FAIL reset_err: got %h exp 00", err_count); else n_pass++;
        n_checks++; if (reg_out !== bank()) $display("FAIL reset_regs: got %h exp %h", reg_out, bank()); else n_pass++;
        n_checks++; if (resp_data !== '0) $display("FAIL reset_resp_data: got %h exp 0", resp_data); else n_pass++;
    endtask

    task automatic test_write();
        exp_t e;
        int lat;
        logic [FW-1:0] data;
        sb.push_back('{st:8'h4B, idx:8'h03, val:8'h5A, lat:3});
        exp_regs[3] = 8'h5A;
        send(mk("W", 8'h03, 8'h5A, "W"), lat, data);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL write_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
        n_checks++; if (data !== mk_resp(e)) $display("FAIL write_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        n_checks++; if (reg_out[31:24] !== 8'h5A) $display("FAIL write_reg3: got %h exp 5a", reg_out[31:24]); else n_pass++;
        handshake();
        for (int i = 0; i < NR; i++) begin
            if (i != 3) begin
                sb.push_back('{st:8'h4B, idx:8'(i), val:8'hFF, lat:3});
                send(mk("R", 8'(i), 8'h00, "R"), lat, data);
                e = sb.pop_front();
                n_checks++; if (lat !== e.lat) $display("FAIL read_ff_lat[%0d]: got %0d exp %0d", i, lat, e.lat); else n_pass++;
                n_checks++; if (data !== mk_resp(e)) $display("FAIL read_ff[%0d]: got %h exp %h", i, data, mk_resp(e)); else n_pass++;
                handshake();
            end
        end
    endtask

    task automatic test_read_and_range();
        exp_t e;
        int lat;
        logic [FW-1:0] data;
        sb.push_back('{st:8'h4B, idx:8'h03, val:8'h5A, lat:3});
        send(mk("R", 8'h03, 8'h00, "R"), lat, data);
        e = sb.pop_front();
        n_checks++; if (data !== mk_resp(e)) $display("FAIL read_reg3: got %h exp %h", data, mk_resp(e)); else n_pass++;
        handshake();
        sb.push_back('{st:8'h41, idx:8'h09, val:8'h00, lat:3});
        exp_err++;
        send(mk("W", 8'h09, 8'h11, "W"), lat, data);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL range_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
        n_checks++; if (data !== mk_resp(e)) $display("FAIL range_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        n_checks++; if (reg_out !== bank()) $display("FAIL range_nowrite: got %h exp %h", reg_out, bank()); else n_pass++;
        n_checks++; if (err_count !== sat(exp_err)) $display("FAIL range_err: got %0d exp %0d", err_count, sat(exp_err)); else n_pass++;
        handshake();
    endtask

    task automatic test_marker();
        exp_t e;
        int lat;
        logic [FW-1:0] data;
        sb.push_back('{st:8'h46, idx:8'h00, val:8'h00, lat:2});
        exp_err++;
        send(mk("W", 8'h01, 8'h22, "R"), lat, data);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL marker_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
        n_checks++; if (data !== mk_resp(e)) $display("FAIL marker_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        n_checks++; if (reg_out[15:8] !== 8'hFF) $display("FAIL marker_reg1: got %h exp ff", reg_out[15:8]); else n_pass++;
        n_checks++; if (err_count !== sat(exp_err)) $display("FAIL marker_err: got %0d exp %0d", err_count, sat(exp_err)); else n_pass++;
        handshake();
    endtask

    task automatic test_xor();
        exp_t e;
        int lat;
        logic [FW-1:0] f;
        logic [FW-1:0] data;
        f = mk_enc("W", 8'h02, 8'h5A);
`ifdef CMD_FRAME_EXEC_XOR_EN
        e.st = "K"; e.idx = 8'h02; e.val = 8'h5A; e.lat = 4;
        exp_regs[2] = 8'h5A;
`else
        e.st = "I"; e.idx = f[15:8]; e.val = 8'h00; e.lat = 3;
        exp_err++;
`endif
        sb.push_back(e);
        send(f, lat, data);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL xor_lat: got %0d exp %0d", lat, e.lat); else n_pass++;
        n_checks++; if (data !== mk_resp(e)) $display("FAIL xor_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        n_checks++; if (reg_out !== bank()) $display("FAIL xor_regs: got %h exp %h", reg_out, bank()); else n_pass++;
        n_checks++; if (err_count !== sat(exp_err)) $display("FAIL xor_err: got %0d exp %0d", err_count, sat(exp_err)); else n_pass++;
        handshake();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        logic [FW-1:0] data;
        logic [7:0] idx, val;
        logic is_w;
        for (int n = 0; n < 10; n++) begin
            is_w = 1'($urandom_range(0, 1));
            idx  = 8'($urandom_range(0, 9));
            val  = 8'($urandom_range(0, 255));
            if (idx >= 8'(NR)) begin
                e.st = "A"; e.idx = idx; e.val = 8'h00;
                exp_err++;
            end else if (is_w) begin
                e.st = "K"; e.idx = idx; e.val = val;
                exp_regs[idx[2:0]] = val;
            end else begin
                e.st = "K"; e.idx = idx; e.val = exp_regs[idx[2:0]];
            end
            e.lat = 3;
            sb.push_back(e);
            send(is_w ? mk("W", idx, val, "W") : mk("R", idx, val, "R"), lat, data);
            e = sb.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL b2b_lat[%0d]: got %0d exp %0d", n, lat, e.lat); else n_pass++;
            n_checks++; if (data !== mk_resp(e)) $display("FAIL b2b_resp[%0d]: got %h exp %h", n, data, mk_resp(e)); else n_pass++;
            n_checks++; if (reg_out !== bank()) $display("FAIL b2b_regs[%0d]: got %h exp %h", n, reg_out, bank()); else n_pass++;
            handshake();
            n_checks++; if (frame_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b exp 1", n, frame_ready); else n_pass++;
        end
        n_checks++; if (err_count !== sat(exp_err)) $display("FAIL b2b_err: got %0d exp %0d", err_count, sat(exp_err)); else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        logic [FW-1:0] data, snap;
        logic stable;
        sb.push_back('{st:8'h4B, idx:8'h05, val:8'h33, lat:3});
        exp_regs[5] = 8'h33;
        send(mk("W", 8'h05, 8'h33, "W"), lat, data);
        e = sb.pop_front();
        n_checks++; if (data !== mk_resp(e)) $display("FAIL bp_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        snap = data;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            frame_in    = mk("W", 8'h06, 8'h44, "W");
            frame_valid = (c == 0 || c == 3 || c == 6);
            @(posedge clk);
            #1;
            if (resp_data !== snap || resp_valid !== 1'b1) stable = 1'b0;
        end
        frame_valid = 1'b0;
        exp_err += 3;
        n_checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b exp 1", stable); else n_pass++;
        n_checks++; if (err_count !== sat(exp_err)) $display("FAIL bp_err: got %0d exp %0d", err_count, sat(exp_err)); else n_pass++;
        handshake();
        n_checks++; if (reg_out !== bank()) $display("FAIL bp_dropped: got %h exp %h", reg_out, bank()); else n_pass++;

        sb.push_back('{st:8'h4B, idx:8'h05, val:8'h33, lat:3});
        send(mk("R", 8'h05, 8'h00, "R"), lat, data);
        e = sb.pop_front();
        n_checks++; if (data !== mk_resp(e)) $display("FAIL sat_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        @(negedge clk);
        frame_valid = 1'b1;
        repeat (300) @(negedge clk);
        frame_valid = 1'b0;
        exp_err += 300;
        n_checks++; if (err_count !== 8'hFF) $display("FAIL sat_err: got %0d exp 255", err_count); else n_pass++;
        handshake();
        sb.push_back('{st:8'h46, idx:8'h00, val:8'h00, lat:2});
        send(mk("R", 8'h01, 8'h00, "W"), lat, data);
        e = sb.pop_front();
        n_checks++; if (data !== mk_resp(e)) $display("FAIL sat_f_resp: got %h exp %h", data, mk_resp(e)); else n_pass++;
        n_checks++; if (err_count !== 8'hFF) $display("FAIL sat_nowrap: got %0d exp 255", err_count); else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        logic [FW-1:0] data;
        @(negedge clk);
        frame_in    = mk_enc("W", 8'h02, 8'h77);
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = 8'hFF;
        exp_err = 0;
        #1;
        n_checks++; if (frame_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_state: got ready=%b busy=%b exp 1/0", frame_ready, busy); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL midrst_resp_valid: got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (err_count !== 8'h00) $display("FAIL midrst_err: got %0d exp 0", err_count); else n_pass++;
        n_checks++; if (reg_out !== bank()) $display("FAIL midrst_regs: got %h exp %h", reg_out, bank()); else n_pass++;
        @(negedge clk);
        nreset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b0 || reg_out !== bank()) $display("FAIL midrst_aborted: got valid=%b regs=%h exp 0/%h", resp_valid, reg_out, bank()); else n_pass++;
        sb.push_back('{st:8'h4B, idx:8'h02, val:8'h77, lat:3});
        exp_regs[2] = 8'h77;
        send(mk("W", 8'h02, 8'h77, "W"), lat, data);
        e = sb.pop_front();
        n_checks++; if (data !== mk_resp(e) || lat !== e.lat) $display("FAIL midrst_resume: got %h lat %0d exp %h lat %0d", data, lat, mk_resp(e), e.lat); else n_pass++;
        handshake();
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        exp_err     = 0;
        for (int i = 0; i < NR; i++) exp_regs[i] = 8'hFF;
        nreset      = 1'b0;
        frame_valid = 1'b0;
        frame_in    = '0;
        resp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        test_reset();
        test_write();
        test_read_and_range();
        test_marker();
        test_xor();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
